// File: rtl/vga_pkg.sv
// Shared constants for the VGA framebuffer path: FSM encodings, 640x480@60 timing
// and the default scanline fetch length in 32-pixel words.
package vga_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned H_TOTAL   = 800;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned V_TOTAL   = 525;

    localparam int unsigned WORDS_PER_LINE_DEF = H_VISIBLE / 32;

endpackage

// File: rtl/vga_line_addr_gen.sv
// Scanline fetch address generator: holds the line base address and word index,
// and produces the RAM read address and the last-word flag.
module vga_line_addr_gen #(
    parameter int unsigned AW             = 15,
    parameter int unsigned WORDS_PER_LINE = 20,
    parameter int unsigned LBW            = 5
) (
    input  logic           clk_25,
    input  logic           rst_n,
    input  logic           load,
    input  logic [9:0]     line,
    input  logic           advance,
    output logic [AW-1:0]  mem_addr,
    output logic [LBW-1:0] word_idx,
    output logic           last_word
);

    logic [AW-1:0]  line_base_q, line_base_d;
    logic [LBW-1:0] word_idx_q,  word_idx_d;

    // A restart wins over an advance issued in the same cycle.
    always_comb begin
        line_base_d = line_base_q;
        word_idx_d  = word_idx_q;
        if (load) begin
            line_base_d = AW'({22'd0, line} * WORDS_PER_LINE);
            word_idx_d  = '0;
        end else if (advance) begin
            word_idx_d  = word_idx_q + LBW'(1);
        end
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            line_base_q <= '0;
            word_idx_q  <= '0;
        end else begin
            line_base_q <= line_base_d;
            word_idx_q  <= word_idx_d;
        end
    end

    assign mem_addr  = line_base_q + AW'(word_idx_q);
    assign word_idx  = word_idx_q;
    assign last_word = (word_idx_q == LBW'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: scanline prefetch has priority over a valid/ready pixel
// writer, with a burst guard that hands a waiting writer one slot every MAX_BURST reads.
import vga_pkg::*;

module vga_fb_arbiter #(
    parameter int unsigned AW             = 15,
    parameter int unsigned DW             = 32,
    parameter int unsigned WORDS_PER_LINE = WORDS_PER_LINE_DEF,
    parameter int unsigned LINES          = 480,
    parameter int unsigned MAX_BURST      = 4,
    parameter int unsigned LBW            = 5
) (
    input  logic           clk_25,
    input  logic           rst_n,
    input  logic           fetch_start,
    input  logic [9:0]     fetch_line,
    input  logic           wr_valid,
    output logic           wr_ready,
    input  logic [AW-1:0]  wr_addr,
    input  logic [DW-1:0]  wr_data,
    output logic           mem_en,
    output logic           mem_we,
    output logic [AW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_wdata,
    input  logic [DW-1:0]  mem_rdata,
    output logic           lb_we,
    output logic [LBW-1:0] lb_addr,
    output logic [DW-1:0]  lb_wdata,
    output logic           fetch_busy,
    output logic           fetch_overrun
);

    localparam int unsigned    BCW       = 8;
    localparam logic [BCW-1:0] BURST_LIM = BCW'(MAX_BURST);

    logic [1:0]     state_q,     state_d;
    logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
    logic           rd_pend_q,   rd_pend_d;
    logic [LBW-1:0] rd_idx_q,    rd_idx_d;
    logic           overrun_q,   overrun_d;

    logic           start_ok;
    logic           burst_hit;
    logic           wr_grant;
    logic           fetch_grant;
    logic           last_word;
    logic [AW-1:0]  fetch_addr;
    logic [LBW-1:0] word_idx;

    assign start_ok    = fetch_start && ({22'd0, fetch_line} < LINES);
    assign burst_hit   = (MAX_BURST != 0) && (burst_cnt_q == BURST_LIM) && wr_valid;
    // Grants are gated by rst_n so the RAM sees no access while reset is held.
    assign wr_ready    = rst_n && ((state_q != ST_FETCH) || burst_hit);
    assign wr_grant    = wr_ready && wr_valid;
    assign fetch_grant = rst_n && (state_q == ST_FETCH) && !wr_ready;

    assign mem_en        = wr_grant || fetch_grant;
    assign mem_we        = wr_grant;
    assign mem_addr      = wr_grant ? wr_addr : fetch_addr;
    assign mem_wdata     = wr_data;
    assign lb_we         = rd_pend_q;
    assign lb_addr       = rd_idx_q;
    assign lb_wdata      = mem_rdata;
    assign fetch_busy    = (state_q != ST_IDLE);
    assign fetch_overrun = overrun_q;

    vga_line_addr_gen #(
        .AW             (AW),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .LBW            (LBW)
    ) u_addr_gen (
        .clk_25    (clk_25),
        .rst_n     (rst_n),
        .load      (start_ok),
        .line      (fetch_line),
        .advance   (fetch_grant),
        .mem_addr  (fetch_addr),
        .word_idx  (word_idx),
        .last_word (last_word)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ok) state_d = ST_FETCH;
            ST_FETCH: begin
                if (start_ok)                      state_d = ST_FETCH;
                else if (fetch_grant && last_word) state_d = ST_DRAIN;
            end
            ST_DRAIN: state_d = start_ok ? ST_FETCH : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        overrun_d = start_ok && (state_q != ST_IDLE);

        burst_cnt_d = burst_cnt_q;
        if (!wr_valid || wr_grant)
            burst_cnt_d = '0;
        else if (fetch_grant && (burst_cnt_q != '1))
            burst_cnt_d = burst_cnt_q + BCW'(1);

        rd_pend_d = fetch_grant;
        rd_idx_d  = fetch_grant ? word_idx : rd_idx_q;
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            burst_cnt_q <= '0;
            rd_pend_q   <= 1'b0;
            rd_idx_q    <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            rd_pend_q   <= rd_pend_d;
            rd_idx_q    <= rd_idx_d;
            overrun_q   <= overrun_d;
        end
    end

endmodule
